// File: rtl/seqdet_pkg.sv
// seqdet_pkg: shared constants and helpers for the
// programmable Moore sequence detector.
package seqdet_pkg;

  localparam int SEQ_PAT_W = 5;
  localparam int SEQ_CNT_W = 8;

  localparam logic [4:0] SEQ_DEF_PAT = 5'b10010;
  localparam int         SEQ_DEF_LEN = 5;

  localparam logic OVL_ON  = 1'b1;
  localparam logic OVL_OFF = 1'b0;

  localparam logic SEQ_DEF_OVL = OVL_ON;

  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seqdet_next_state.sv
// seqdet_next_state: combinational prefix-match step.
// Ports: st, ain, pattern, len, ovl in; st_next out.
module seqdet_next_state
  import seqdet_pkg::*;
#(
  parameter int PAT_W = SEQ_PAT_W,
  localparam int LEN_W = len_w(PAT_W)
) (
  input  logic [LEN_W-1:0] st,
  input  logic             ain,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic             ovl,
  output logic [LEN_W-1:0] st_next
);

  logic [LEN_W-1:0] s;
  logic [PAT_W-1:0] pa;
  logic [PAT_W:0]   h;
  logic             hit;

  // pa: pattern left-aligned, first bit at MSB.
  // h: matched prefix followed by ain, newest
  // bit at LSB, so the last j bits are h[j-1:0].
  always_comb begin
    s       = st;
    hit     = 1'b0;
    st_next = '0;
    if (st == len && ovl == OVL_OFF)
      s = '0;
    pa = pattern << (PAT_W - int'(len));
    h  = {pa >> (PAT_W - int'(s)), ain};
    for (int j = 1; j <= PAT_W; j++) begin
      hit = (j <= int'(s) + 1) &&
            (j <= int'(len));
      for (int k = 0; k < j; k++)
        if (pa[PAT_W-1-k] != h[j-1-k])
          hit = 1'b0;
      if (hit)
        st_next = LEN_W'(j);
    end
  end

endmodule

// File: rtl/seqdet_prog_moore.sv
// seqdet_prog_moore: run-time programmable serial
// sequence detector, Moore match flag.
// Ports: clk, rst (sync, high), en, ain, cfg_load,
// cfg_pattern, cfg_len, cfg_ovl in; zout,
// match_cnt, cfg_err out.
// Macro SEQDET_MATCH_CNT_EN enables the match
// counter; otherwise match_cnt is tied to 0.
module seqdet_prog_moore
  import seqdet_pkg::*;
#(
  parameter int PAT_W = SEQ_PAT_W,
  parameter int CNT_W = SEQ_CNT_W,
  parameter logic [PAT_W-1:0] DEF_PAT =
    PAT_W'(SEQ_DEF_PAT),
  parameter int DEF_LEN = SEQ_DEF_LEN,
  parameter logic DEF_OVL = SEQ_DEF_OVL,
  localparam int LEN_W = len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ain,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_ovl,
  output logic             zout,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cfg_err
);

  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [LEN_W-1:0] st;
  logic [LEN_W-1:0] st_next;
  logic             cfg_ok;

  assign cfg_ok = cfg_load &&
                  (cfg_len != '0) &&
                  (int'(cfg_len) <= PAT_W);

  seqdet_next_state #(
    .PAT_W(PAT_W)
  ) u_ns (
    .st     (st),
    .ain    (ain),
    .pattern(pat_q),
    .len    (len_q),
    .ovl    (ovl_q),
    .st_next(st_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= '0;
      pat_q   <= DEF_PAT;
      len_q   <= LEN_W'(DEF_LEN);
      ovl_q   <= DEF_OVL;
      cfg_err <= 1'b0;
    end else if (cfg_ok) begin
      st      <= '0;
      pat_q   <= cfg_pattern;
      len_q   <= cfg_len;
      ovl_q   <= cfg_ovl;
      cfg_err <= 1'b0;
    end else begin
      if (cfg_load)
        cfg_err <= 1'b1;
      if (en)
        st <= st_next;
    end
  end

  assign zout = (st == len_q);

`ifdef SEQDET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || cfg_ok)
      cnt_q <= '0;
    else if (en && st_next == len_q &&
             cnt_q != '1)
      cnt_q <= cnt_q + CNT_W'(1);
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seqdet_prog_moore.sv
// tb_seqdet_prog_moore: scoreboard bench with a
// history-based reference model.
module tb_seqdet_prog_moore;

  localparam int PAT_W = 5;
  localparam int LEN_W = 3;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic             ain = 1'b0;
  logic             cfg_load = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_ovl = 1'b0;
  logic             zout;
  logic [CNT_W-1:0] match_cnt;
  logic             cfg_err;

  seqdet_prog_moore dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .ain        (ain),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_ovl    (cfg_ovl),
    .zout       (zout),
    .match_cnt  (match_cnt),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit z;
    int cnt;
    bit err;
  } exp_t;

  exp_t q[$];
  int   vecs = 0;
  int   miss = 0;

  // Reference model: the bits received since the
  // last restart; a match is the pattern appearing
  // as a suffix of that history.
  bit         hist[$];
  logic [4:0] mpat = 5'b10010;
  int         mlen = 5;
  bit         movl = 1'b1;
  bit         mz = 1'b0;
  int         mcnt = 0;
  bit         merr = 1'b0;

  function automatic bit suffix_match();
    int n;
    n = hist.size();
    if (n < mlen) return 1'b0;
    for (int k = 0; k < mlen; k++)
      if (hist[n-mlen+k] != mpat[mlen-1-k])
        return 1'b0;
    return 1'b1;
  endfunction

  task automatic model(
    input bit e, input bit a, input bit r,
    input bit ld, input logic [4:0] p,
    input int l, input bit o
  );
    bit m;
    if (r) begin
      mpat = 5'b10010; mlen = 5; movl = 1'b1;
      hist.delete(); mz = 1'b0;
      mcnt = 0; merr = 1'b0;
    end else if (ld && l >= 1 && l <= PAT_W) begin
      mpat = p; mlen = l; movl = o;
      hist.delete(); mz = 1'b0;
      mcnt = 0; merr = 1'b0;
    end else begin
      if (ld) merr = 1'b1;
      if (e) begin
        hist.push_back(a);
        if (hist.size() > PAT_W)
          void'(hist.pop_front());
        m = suffix_match();
        mz = m;
        if (m && mcnt < CMAX) mcnt++;
        if (m && !movl) hist.delete();
      end
    end
  endtask

  task automatic step(
    input bit e, input bit a,
    input bit r = 1'b0, input bit ld = 1'b0,
    input logic [4:0] p = '0,
    input logic [2:0] l = '0,
    input bit o = 1'b0
  );
    exp_t x;
    @(negedge clk);
    rst = r; en = e; ain = a;
    cfg_load = ld; cfg_pattern = p;
    cfg_len = l; cfg_ovl = o;
    model(e, a, r, ld, p, int'(l), o);
    x.z = mz;
`ifdef SEQDET_MATCH_CNT_EN
    x.cnt = mcnt;
`else
    x.cnt = 0;
`endif
    x.err = merr;
    q.push_back(x);
  endtask

  task automatic feed(
    input logic [31:0] bits, input int n
  );
    for (int i = n - 1; i >= 0; i--)
      step(1'b1, bits[i]);
  endtask

  task automatic load(
    input logic [4:0] p,
    input logic [2:0] l, input bit o
  );
    step(1'b0, 1'b0, 1'b0, 1'b1, p, l, o);
  endtask

  // Monitor: the DUT presents a new state each
  // clock; compare it to the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        exp_t x;
        x = q.pop_front();
        vecs++;
        if (zout !== x.z) begin
          miss++;
          $display("FAIL zout v%0d: got %b want %b",
                   vecs, zout, x.z);
        end
        if (int'(match_cnt) != x.cnt ||
            $isunknown(match_cnt)) begin
          miss++;
          $display("FAIL cnt v%0d: got %0d want %0d",
                   vecs, match_cnt, x.cnt);
        end
        if (cfg_err !== x.err) begin
          miss++;
          $display("FAIL err v%0d: got %b want %b",
                   vecs, cfg_err, x.err);
        end
      end
    end
  end

  initial begin
    int r;
    // 1: defaults, overlapping 10010
    step(1'b0, 1'b0, 1'b1);
    feed(32'b10010010, 8);
    // 2: non-overlapping
    load(5'b10010, 3'd5, 1'b0);
    feed(32'b10010010, 8);
    // 3: 111 with and without overlap
    load(5'b00111, 3'd3, 1'b1);
    feed(32'b11111, 5);
    load(5'b00111, 3'd3, 1'b0);
    feed(32'b11111, 5);
    // 4: en gaps hold the state and the flag
    step(1'b0, 1'b0, 1'b1);
    feed(32'b1001, 4);
    repeat (4) step(1'b0, 1'($urandom));
    step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'($urandom));
    // 5: rejected configs keep the old pattern
    load(5'b11111, 3'd0, 1'b0);
    load(5'b11111, 3'd6, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 5'b0, 3'd7);
    feed(32'b0010010, 7);
    load(5'b00101, 3'd3, 1'b1);
    feed(32'b10101, 5);
    // 6: len 1, counter saturation, reset
    load(5'b11001, 3'd1, 1'b1);
    repeat (CMAX + 6) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    feed(32'b1001, 4);
    step(1'b1, 1'b1, 1'b1, 1'b1,
         5'b00001, 3'd1, 1'b1);
    step(1'b1, 1'b0);
    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 5)
        step(1'($urandom), 1'($urandom), 1'b1);
      else if (r < 35)
        step(1'($urandom), 1'($urandom), 1'b0,
             1'b1, 5'($urandom),
             3'($urandom_range(0, 7)),
             1'($urandom));
      else
        step(($urandom_range(0, 9) < 8),
             1'($urandom));
    end
    step(1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      miss++;
      $display("FAIL drain: got %0d left want 0",
               q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miss);
    $finish;
  end

endmodule
